// File: rtl/fetch_decode_seq.sv
// fetch_decode_seq: multi-cycle FETCH-DECODE-EXEC-WB instruction sequencer.
// Holds the PC, fetches 32-bit words over a req/ack handshake, and decodes
// them into register-file, ALU and data-memory controls. An instruction
// whose low 25 bits are all zero halts the core until reset.
// Optional macro FETCH_DECODE_INSTRET_EN adds a 32-bit retired-instruction
// counter output (instret).
module fetch_decode_seq #(
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [4:0]      rf_src1,
    output logic [4:0]      rf_src2,
    output logic [4:0]      rf_dst,
    output logic            rf_w,
    output logic            alu_op,
    output logic [31:0]     imm_v,
    output logic            mem_w,
    output logic            ld_sel,
    output logic [PC_W-1:0] pc,
    output logic            halted
`ifdef FETCH_DECODE_INSTRET_EN
    ,
    output logic [31:0]     instret
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state;
    state_t          state_next;
    logic [24:0]     ir;           // bits [31:25] of the word carry no meaning
    logic            fetch_take;
    logic [PC_W-1:0] br_off;
    logic            unused_hi;

    // Field view of the instruction register.
    logic br;
    logic mw;
    logic rw;
    logic signed [4:0] imm5;

    assign br   = ir[24];
    assign mw   = ir[23];
    assign rw   = ir[22];
    assign imm5 = ir[19:15];

    assign unused_hi = &{1'b0, imem_data[31:25]};

    // A word is only taken while a request is actually outstanding.
    assign fetch_take = (state == FETCH) && imem_req && imem_ack;

    assign br_off    = {{(PC_W-5){imm5[4]}}, imm5};
    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign rf_src1   = ir[9:5];
    assign rf_src2   = ir[4:0];
    assign rf_dst    = ir[14:10];
    assign alu_op    = ir[21];
    assign ld_sel    = ir[20];
    assign imm_v     = {{27{imm5[4]}}, imm5};

    // Next-state logic for the instruction loop.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (fetch_take) state_next = DECODE;
            DECODE:  state_next = (ir == 25'd0) ? HALT : EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // State, instruction register, registered strobes and PC update.
    // Strobes are registered so they are glitch-free for the whole cycle
    // and clear asynchronously the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            ir       <= '0;
            imem_req <= 1'b0;
            rf_w     <= 1'b0;
            mem_w    <= 1'b0;
            pc       <= RESET_PC;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == FETCH);
            rf_w     <= (state_next == WB) && rw;
            mem_w    <= (state_next == WB) && mw;
            if (fetch_take) begin
                ir <= imem_data[24:0];
            end
            if (state == WB) begin
                pc <= br ? (pc + br_off) : (pc + PC_ONE);
            end
        end
    end

`ifdef FETCH_DECODE_INSTRET_EN
    // Retired-instruction counter: one count per completed writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (state == WB) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed testbench for fetch_decode_seq: reset, decode fields, wait
// states, back-to-back timing, branches, halt, reset mid-writeback, PC wrap.
module tb_fetch_decode_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [4:0]  rf_src1, rf_src2, rf_dst;
    logic        rf_w, alu_op, mem_w, ld_sel, halted;
    logic [31:0] imm_v;
    logic [31:0] pc;
`ifdef FETCH_DECODE_INSTRET_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad = 0;

    fetch_decode_seq dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_dst(rf_dst),
        .rf_w(rf_w), .alu_op(alu_op), .imm_v(imm_v),
        .mem_w(mem_w), .ld_sel(ld_sel), .pc(pc), .halted(halted)
`ifdef FETCH_DECODE_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Waits (bounded) for a fetch request, then acks it with 'word' in the
    // same cycle. Returns at the negedge of the DECODE cycle.
    task automatic issue(input logic [31:0] word);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (imem_req) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL issue_req got=0 want=1");
        end
        imem_data = word;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        step(3);
        total++;
        if ({pc, imem_req, rf_w, mem_w, halted} !== {32'd0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_state got=%h/%b%b%b%b want=0/0000", pc, imem_req, rf_w, mem_w, halted);
        end
        total++;
        if ({imm_v, rf_dst, rf_src1, rf_src2} !== 47'd0) begin
            bad++;
            $display("FAIL reset_fields got=%h %h %h %h want=0", imm_v, rf_dst, rf_src1, rf_src2);
        end
        // Release with ack already high: it must be ignored (req still 0).
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'h0200001;
        @(negedge clk);
        imem_ack  = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL release_req got=%b/%h want=1/0", imem_req, imem_addr);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL early_ack_ignored got=%b want=1", imem_req);
        end
    endtask

    // 0x0C08400: mw=1 rw=1 op=0 imm5=1 dst=1
    task automatic test_imm_write;
        issue(32'h0C08400);
        total++;
        if (imm_v !== 32'd1 || rf_dst !== 5'd1 || alu_op !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL imm_decode got=%h %h %b %b want=1 1 0 0", imm_v, rf_dst, alu_op, imem_req);
        end
        total++;
        if (rf_w !== 1'b0 || mem_w !== 1'b0) begin
            bad++;
            $display("FAIL imm_decode_strobe got=%b%b want=00", rf_w, mem_w);
        end
        step(1);
        total++;
        if (rf_w !== 1'b0 || mem_w !== 1'b0) begin
            bad++;
            $display("FAIL imm_exec_strobe got=%b%b want=00", rf_w, mem_w);
        end
        step(1);
        total++;
        if (rf_w !== 1'b1 || mem_w !== 1'b1) begin
            bad++;
            $display("FAIL imm_wb_strobe got=%b%b want=11", rf_w, mem_w);
        end
        step(1);
        total++;
        if (rf_w !== 1'b0 || mem_w !== 1'b0 || pc !== 32'd1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL imm_next got=%b%b pc=%h req=%b want=00 pc=1 req=1", rf_w, mem_w, pc, imem_req);
        end
    endtask

    // 0x780CA7: rw=1 op=1 ld=1 imm5=-16 dst=3 src1=5 src2=7
    task automatic test_fields;
        issue(32'h0780CA7);
        total++;
        if ({rf_src1, rf_src2, rf_dst, alu_op, ld_sel} !== {5'd5, 5'd7, 5'd3, 2'b11} || imm_v !== 32'hFFFFFFF0) begin
            bad++;
            $display("FAIL fields got=%h %h %h %b %b %h want=5 7 3 1 1 fffffff0", rf_src1, rf_src2, rf_dst, alu_op, ld_sel, imm_v);
        end
        step(2);
        total++;
        if (rf_w !== 1'b1 || mem_w !== 1'b0 || rf_dst !== 5'd3 || imm_v !== 32'hFFFFFFF0) begin
            bad++;
            $display("FAIL fields_wb got=%b%b %h %h want=10 3 fffffff0", rf_w, mem_w, rf_dst, imm_v);
        end
        step(1);
        total++;
        if (pc !== 32'd2) begin
            bad++;
            $display("FAIL fields_pc got=%h want=2", pc);
        end
    endtask

    // 0x800040: mw=1 src1=2, acked after 3 wait cycles
    task automatic test_wait_states;
        bit ok;
        ok = 1'b1;
        imem_data = 32'h0800040;
        for (int i = 0; i < 3; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'd2 || rf_src1 !== 5'd5) ok = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_stable got=req%b addr%h src1=%h want=req1 addr2 src1=5", imem_req, imem_addr, rf_src1);
        end
        issue(32'h0800040);
        total++;
        if (rf_src1 !== 5'd2 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL wait_load got=%h req=%b want=2 req=0", rf_src1, imem_req);
        end
        step(2);
        total++;
        if (rf_w !== 1'b0 || mem_w !== 1'b1) begin
            bad++;
            $display("FAIL wait_wb got=%b%b want=01", rf_w, mem_w);
        end
        step(1);
    endtask

    // 0x0200001: plain op, no strobes; next request exactly 4 clocks later.
    task automatic test_back_to_back;
        issue(32'h0200001);
        step(2);
        total++;
        if (imem_req !== 1'b0 || rf_w !== 1'b0 || mem_w !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wb got=%b%b%b want=000", imem_req, rf_w, mem_w);
        end
        step(1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
            bad++;
            $display("FAIL b2b_next got=%b/%h want=1/4", imem_req, imem_addr);
        end
    endtask

    // 0x14F8000: br=1 rw=1 imm5=-1 at pc=4
    task automatic test_branch;
        issue(32'h14F8000);
        total++;
        if (imm_v !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL br_imm got=%h want=ffffffff", imm_v);
        end
        step(2);
        total++;
        if (rf_w !== 1'b1) begin
            bad++;
            $display("FAIL br_rf_w got=%b want=1", rf_w);
        end
        step(1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd3) begin
            bad++;
            $display("FAIL br_target got=%b/%h want=1/3", imem_req, imem_addr);
        end
    endtask

    // Upper bits set but [24:0]=0 still halts.
    task automatic test_halt;
        bit ok;
        issue(32'hFE000000);
        total++;
        if (halted !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL halt_decode got=%b%b want=00", halted, imem_req);
        end
        step(1);
        ok = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'h0C08400;
        for (int i = 0; i < 6; i++) begin
            if (halted !== 1'b1 || imem_req !== 1'b0 || rf_w !== 1'b0 || mem_w !== 1'b0 || pc !== 32'd3) ok = 1'b0;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL halt_hold got=h%b r%b w%b%b pc=%h want=h1 r0 w00 pc=3", halted, imem_req, rf_w, mem_w, pc);
        end
`ifdef FETCH_DECODE_INSTRET_EN
        total++;
        if (instret !== 32'd5) begin
            bad++;
            $display("FAIL instret got=%0d want=5", instret);
        end
`endif
    endtask

    task automatic test_reset_mid_op;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        issue(32'h0C08400);
        step(2);
        total++;
        if (rf_w !== 1'b1) begin
            bad++;
            $display("FAIL midop_wb got=%b want=1", rf_w);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rf_w, mem_w, halted, imem_req} !== 4'b0000 || imm_v !== 32'd0) begin
            bad++;
            $display("FAIL midop_reset got=%b%b%b%b imm=%h want=0000 imm=0", rf_w, mem_w, halted, imem_req, imm_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL midop_restart got=%b/%h want=1/0", imem_req, imem_addr);
        end
    endtask

    // Self-loop, backward wrap below zero, forward wrap past the top.
    task automatic test_pc_wrap;
        issue(32'h1000000);
        step(3);
        total++;
        if (imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL self_loop got=%h want=0", imem_addr);
        end
        issue(32'h10F8000);
        step(3);
        total++;
        if (imem_addr !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL wrap_down got=%h want=ffffffff", imem_addr);
        end
        issue(32'h0200001);
        step(3);
        total++;
        if (imem_addr !== 32'd0 || pc !== 32'd0) begin
            bad++;
            $display("FAIL wrap_up got=%h/%h want=0/0", imem_addr, pc);
        end
    endtask

    initial begin
        test_reset;
        test_imm_write;
        test_fields;
        test_wait_states;
        test_back_to_back;
        test_branch;
        test_halt;
        test_reset_mid_op;
        test_pc_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
